// File: rtl/enemy_agent.sv
// enemy_agent -- per-slot enemy controller, advanced once per game frame.
//
// Tracks position, hit points and behaviour through an explicit FSM:
// spawn/death life-cycle, chase toward the player, wind-up and attack with
// an attack_req/attack_ack handshake, and stun with knockback.
//
// Build option: define ENEMY_DIAG_MOVE_EN to let CHASE move on both axes in
// one frame; by default CHASE moves on a single axis chosen by priority
// (right, left, down, up).
//
// Ports:
//   game_frame_clk_rising_edge  clock, one edge per game frame
//   Reset                       synchronous, active-high
//   spawn                       pulse, activates the enemy while DEAD
//   player_x, player_y          player box top-left
//   hit, hit_dmg                enemy struck this frame, damage (0 counts as 1)
//   attack_ack                  damage arbiter accepted the attack
//   pos_x, pos_y                enemy box top-left
//   dir                         facing: 0 down, 1 left, 2 up, 3 right
//   state                       FSM state code
//   hp                          remaining hit points
//   alive                       high in CHASE/WINDUP/ATTACK/STUN
//   attack_req                  attack request to the arbiter
//   anim_frame                  walk animation step
//   died                        one-frame pulse on DYING -> DEAD
//
// state  | meaning
// DEAD   | inactive, waits for spawn
// CHASE  | walking toward the player
// WINDUP | adjacent, counting down to an attack (also the post-attack cooldown)
// ATTACK | attack_req held until ack or timeout
// STUN   | knocked back after a hit, counting down
// DYING  | death animation, counting down to DEAD

module enemy_agent #(
    parameter int COORD_W        = 9,
    parameter int X_START        = 70,
    parameter int Y_START        = 60,
    parameter int WIDTH          = 26,
    parameter int HEIGHT         = 26,
    parameter int PLAYER_W       = 18,
    parameter int PLAYER_H       = 20,
    parameter int STEP           = 1,
    parameter int KNOCK_STEP     = 3,
    parameter int HP_MAX         = 3,
    parameter int ATTACK_DIST    = 3,
    parameter int WINDUP_FRAMES  = 4,
    parameter int ATTACK_TIMEOUT = 8,
    parameter int STUN_FRAMES    = 6,
    parameter int DYING_FRAMES   = 8,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 319,
    parameter int Y_MIN          = 52,
    parameter int Y_MAX          = 205
) (
    input  logic               game_frame_clk_rising_edge,
    input  logic               Reset,
    input  logic               spawn,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic               hit,
    input  logic [3:0]         hit_dmg,
    input  logic               attack_ack,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         dir,
    output logic [2:0]         state,
    output logic [3:0]         hp,
    output logic               alive,
    output logic               attack_req,
    output logic [1:0]         anim_frame,
    output logic               died
);

    // Two guard bits so box arithmetic never wraps.
    localparam int W2 = COORD_W + 2;

    localparam logic [W2-1:0] X_LO  = W2'(X_MIN);
    localparam logic [W2-1:0] X_HI  = W2'(X_MAX - WIDTH);
    localparam logic [W2-1:0] Y_LO  = W2'(Y_MIN);
    localparam logic [W2-1:0] Y_HI  = W2'(Y_MAX - HEIGHT);
    localparam logic [W2-1:0] STP   = W2'(STEP);
    localparam logic [W2-1:0] KSTP  = W2'(KNOCK_STEP);
    localparam logic [W2-1:0] E_W   = W2'(WIDTH);
    localparam logic [W2-1:0] E_H   = W2'(HEIGHT);
    localparam logic [W2-1:0] P_W   = W2'(PLAYER_W);
    localparam logic [W2-1:0] P_H   = W2'(PLAYER_H);
    localparam logic [W2-1:0] ADIST = W2'(ATTACK_DIST);

    typedef enum logic [2:0] {
        S_DEAD   = 3'd0,
        S_CHASE  = 3'd1,
        S_WINDUP = 3'd2,
        S_ATTACK = 3'd3,
        S_STUN   = 3'd4,
        S_DYING  = 3'd5
    } state_t;

    state_t     st;
    logic [7:0] cnt;

    assign state = st;

    function automatic logic [W2-1:0] inc_clamp(input logic [W2-1:0] v,
                                                input logic [W2-1:0] s,
                                                input logic [W2-1:0] hi);
        inc_clamp = (v + s > hi) ? hi : v + s;
    endfunction

    function automatic logic [W2-1:0] dec_clamp(input logic [W2-1:0] v,
                                                input logic [W2-1:0] s,
                                                input logic [W2-1:0] lo);
        dec_clamp = (v < lo + s) ? lo : v - s;
    endfunction

    logic [W2-1:0] ex, ey, px, py;
    logic          go_r, go_l, go_d, go_u, adjacent;

    assign ex = {2'b00, pos_x};
    assign ey = {2'b00, pos_y};
    assign px = {2'b00, player_x};
    assign py = {2'b00, player_y};

    assign go_r = (ex + E_W) < px;
    assign go_l = ex > (px + P_W);
    assign go_d = (ey + E_H) < py;
    assign go_u = ey > (py + P_H);

    // Inclusive box edges: touching after the ATTACK_DIST expansion counts.
    assign adjacent = (ex + E_W + ADIST >= px) && (px + P_W + ADIST >= ex) &&
                      (ey + E_H + ADIST >= py) && (py + P_H + ADIST >= ey);

    logic [W2-1:0] nx, ny, kx, ky;
    logic [1:0]    ndir;
    logic          mv, moved;

    always_comb begin
        nx   = ex;
        ny   = ey;
        ndir = dir;
        mv   = 1'b0;
`ifdef ENEMY_DIAG_MOVE_EN
        if (go_r) begin
            nx = inc_clamp(ex, STP, X_HI); ndir = 2'd3; mv = 1'b1;
        end else if (go_l) begin
            nx = dec_clamp(ex, STP, X_LO); ndir = 2'd1; mv = 1'b1;
        end
        if (go_d) begin
            ny = inc_clamp(ey, STP, Y_HI); mv = 1'b1;
            if (!(go_r || go_l)) ndir = 2'd0;
        end else if (go_u) begin
            ny = dec_clamp(ey, STP, Y_LO); mv = 1'b1;
            if (!(go_r || go_l)) ndir = 2'd2;
        end
`else
        if (go_r) begin
            nx = inc_clamp(ex, STP, X_HI); ndir = 2'd3; mv = 1'b1;
        end else if (go_l) begin
            nx = dec_clamp(ex, STP, X_LO); ndir = 2'd1; mv = 1'b1;
        end else if (go_d) begin
            ny = inc_clamp(ey, STP, Y_HI); ndir = 2'd0; mv = 1'b1;
        end else if (go_u) begin
            ny = dec_clamp(ey, STP, Y_LO); ndir = 2'd2; mv = 1'b1;
        end
`endif
    end

    // A clamped move still turns the enemy but must not advance the walk cycle.
    assign moved = (nx != ex) || (ny != ey);

    // Knockback pushes opposite to the current facing.
    always_comb begin
        kx = ex;
        ky = ey;
        case (dir)
            2'd0: ky = dec_clamp(ey, KSTP, Y_LO);
            2'd1: kx = inc_clamp(ex, KSTP, X_HI);
            2'd2: ky = inc_clamp(ey, KSTP, Y_HI);
            default: kx = dec_clamp(ex, KSTP, X_LO);
        endcase
    end

    logic [3:0] dmg, hp_new;
    assign dmg    = (hit_dmg == 4'd0) ? 4'd1 : hit_dmg;
    assign hp_new = (hp > dmg) ? hp - dmg : 4'd0;

    always_ff @(posedge game_frame_clk_rising_edge) begin
        if (Reset) begin
            st         <= S_DEAD;
            cnt        <= 8'd0;
            pos_x      <= COORD_W'(X_START);
            pos_y      <= COORD_W'(Y_START);
            dir        <= 2'd0;
            hp         <= 4'd0;
            alive      <= 1'b0;
            attack_req <= 1'b0;
            anim_frame <= 2'd0;
            died       <= 1'b0;
        end else begin
            died <= 1'b0;
            case (st)
                S_DEAD: begin
                    if (spawn) begin
                        st    <= S_CHASE;
                        hp    <= 4'(HP_MAX);
                        pos_x <= COORD_W'(X_START);
                        pos_y <= COORD_W'(Y_START);
                        dir   <= 2'd0;
                        cnt   <= 8'd0;
                        alive <= 1'b1;
                    end
                end

                S_DYING: begin
                    if (cnt <= 8'd1) begin
                        st   <= S_DEAD;
                        cnt  <= 8'd0;
                        died <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                S_CHASE, S_WINDUP, S_ATTACK, S_STUN: begin
                    if (hit) begin
                        attack_req <= 1'b0;
                        hp         <= hp_new;
                        if (hp_new == 4'd0) begin
                            st    <= S_DYING;
                            cnt   <= 8'(DYING_FRAMES);
                            alive <= 1'b0;
                        end else begin
                            st    <= S_STUN;
                            cnt   <= 8'(STUN_FRAMES);
                            pos_x <= kx[COORD_W-1:0];
                            pos_y <= ky[COORD_W-1:0];
                        end
                    end else begin
                        case (st)
                            S_CHASE: begin
                                if (adjacent) begin
                                    st  <= S_WINDUP;
                                    cnt <= 8'(WINDUP_FRAMES);
                                end else begin
                                    pos_x <= nx[COORD_W-1:0];
                                    pos_y <= ny[COORD_W-1:0];
                                    if (mv)    dir        <= ndir;
                                    if (moved) anim_frame <= anim_frame + 2'd1;
                                end
                            end
                            S_WINDUP: begin
                                if (!adjacent) begin
                                    st  <= S_CHASE;
                                    cnt <= 8'd0;
                                end else if (cnt <= 8'd1) begin
                                    st         <= S_ATTACK;
                                    cnt        <= 8'(ATTACK_TIMEOUT);
                                    attack_req <= 1'b1;
                                end else begin
                                    cnt <= cnt - 8'd1;
                                end
                            end
                            S_ATTACK: begin
                                if (attack_ack) begin
                                    st         <= S_WINDUP;
                                    cnt        <= 8'(WINDUP_FRAMES);
                                    attack_req <= 1'b0;
                                end else if (cnt <= 8'd1) begin
                                    st         <= S_CHASE;
                                    cnt        <= 8'd0;
                                    attack_req <= 1'b0;
                                end else begin
                                    cnt <= cnt - 8'd1;
                                end
                            end
                            default: begin
                                if (cnt <= 8'd1) begin
                                    st  <= S_CHASE;
                                    cnt <= 8'd0;
                                end else begin
                                    cnt <= cnt - 8'd1;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    st         <= S_DEAD;
                    cnt        <= 8'd0;
                    alive      <= 1'b0;
                    attack_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
